alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the single shared 16-bit ALU in the RISC processor datapath. It accepts operations from two clients over valid/ready handshakes and grants the ALU round-robin. For the granted operation it drives the ALU inputs from registers, captures result and zero flag, and returns them to the winning client over a held response handshake. It sits between the ALU instance and its users (e.g. execute stage and address/branch unit).

## Interface

Parameters:
- PC_WIDTH, 16, datapath width of operands and result

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  PC_WIDTH  requester 0 operands
- req0_ctrl  in  3  requester 0 ALU opcode
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 consumes result
- req1_* / resp1_*  same as requester 0, for requester 1
- resp_result  out  PC_WIDTH  captured ALU result (shared by both responses)
- resp_zero  out  1  captured ALU zero flag
- alu_in_a, alu_in_b  out  PC_WIDTH  to shared ALU
- alu_ctrl  out  3  to shared ALU
- alu_result  in  PC_WIDTH  from shared ALU (combinational)
- alu_zero  in  1  from shared ALU
- busy  out  1  state != IDLE
- grant_id  out  1  requester index of current/last accepted operation

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither valid: stay.
  - If exactly one valid: grant it.
  - If both valid: grant the one indicated by the priority pointer `prio`.
  - reqN_ready = (state==IDLE) && granted N; combinational, at most one high.
  - On the accept edge: latch a, b, ctrl into operand registers; grant_id <= N; go EXEC.
- EXEC:
  - alu_in_a/alu_in_b/alu_ctrl are driven from the operand registers at all times, never from request ports.
  - On the edge: resp_result <= alu_result, resp_zero <= alu_zero; go RESP.
- RESP:
  - resp{grant_id}_valid = 1; the other resp valid = 0.
  - resp_result/resp_zero held stable.
  - On an edge with the matching resp_ready=1: go IDLE; prio <= ~grant_id.
- Round-robin: `prio` updates only on response completion. A lone requester may be served back-to-back.
- Requests arriving while busy are not accepted; requesters hold valid and operands until ready.
- Reset (asynchronous, any state, including mid-EXEC/RESP):
  - state=IDLE, prio=0, grant_id=0.
  - Operand registers, resp_result = 0, resp_zero = 0.
  - All ready/valid outputs = 0. In-flight operation discarded.
- Arithmetic is entirely in the ALU; this block does no width conversion. Operands and result are PC_WIDTH bits, with no truncation or extension.

## Timing

- Edge E0: request accepted. Edge E1: result captured. resp_valid is high from after E1.
- Earliest completion is edge E2; the next accept is possible at E3. Throughput is 1 op per 3 cycles when the response is consumed immediately.
- Response latency from accept to resp_valid is 1 cycle. resp_valid stays high indefinitely under resp_ready=0 backpressure.
- reqN_ready depends combinationally on reqN_valid and state; no other output path is combinational from inputs.
- busy: 0 in IDLE, 1 in EXEC and RESP.
- resp_ready asserted outside RESP, or on the non-granted port, has no effect.

## Test plan

- Reset, then req0 a=0x0005 b=0x0003 ctrl=000 -> req0_ready high in IDLE cycle; resp0_valid after 1 cycle with resp_result=0x0008, resp_zero=0; resp1_valid stays 0.
- Both valid every cycle, immediate resp_ready -> grants alternate 0,1,0,1 (prio starts 0). Ops: req0 sub 7-7 gives result 0 and zero=1; req1 slt 2<9 gives result 1.
- req1 only, repeated -> served back-to-back at 3-cycle spacing; req0 never readied.
- resp0_ready held low 5 cycles in RESP -> resp0_valid, resp_result and busy stay stable; req1_valid asserted meanwhile -> req1_ready stays 0 until after completion, then req1 is granted.
- Operands changed on request ports after accept -> alu_in_a/b/ctrl and the result reflect the latched values only.
- rst_n pulsed low during EXEC and again during RESP -> outputs go to reset values immediately; after release, a new req0 is processed correctly with prio=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for one shared ALU serving two clients.
// Each operation runs IDLE (accept) -> EXEC (capture result) -> RESP (held until consumed).
module alu_arbiter #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [PC_WIDTH-1:0] req0_a,
  input  logic [PC_WIDTH-1:0] req0_b,
  input  logic [2:0]          req0_ctrl,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [PC_WIDTH-1:0] req1_a,
  input  logic [PC_WIDTH-1:0] req1_b,
  input  logic [2:0]          req1_ctrl,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [PC_WIDTH-1:0] resp_result,
  output logic                resp_zero,
  output logic [PC_WIDTH-1:0] alu_in_a,
  output logic [PC_WIDTH-1:0] alu_in_b,
  output logic [2:0]          alu_ctrl,
  input  logic [PC_WIDTH-1:0] alu_result,
  input  logic                alu_zero,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic                prio;
  logic [PC_WIDTH-1:0] op_a;
  logic [PC_WIDTH-1:0] op_b;
  logic [2:0]          op_ctrl;
  logic                pick1;
  logic                resp_ready_sel;

  // Requester 1 wins when it is alone or when both ask and the pointer favours it.
  assign pick1      = req1_valid && (!req0_valid || prio);
  assign req0_ready = (state == IDLE) && req0_valid && !pick1;
  assign req1_ready = (state == IDLE) && pick1;

  assign resp_ready_sel = grant_id ? resp1_ready : resp0_ready;
  assign resp0_valid    = (state == RESP) && !grant_id;
  assign resp1_valid    = (state == RESP) && grant_id;
  assign busy           = (state != IDLE);

  // The ALU only ever sees latched operands, so requesters may change ports after accept.
  assign alu_in_a = op_a;
  assign alu_in_b = op_b;
  assign alu_ctrl = op_ctrl;

  // NOTE: every register here, operands included, is in the async reset so an
  // aborted operation leaves no stale values visible on the ALU or response ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      grant_id    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every branch reading pre-edge values.
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a     <= pick1 ? req1_a    : req0_a;
            op_b     <= pick1 ? req1_b    : req0_b;
            op_ctrl  <= pick1 ? req1_ctrl : req0_ctrl;
            grant_id <= pick1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          state       <= RESP;
        end
        RESP: begin
          // Pointer moves only on completion, so a lone requester can be served back-to-back.
          if (resp_ready_sel) begin
            prio  <= ~grant_id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

  localparam int W = 16;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ANDO = 3'b010, ORO = 3'b011,
                         XORO = 3'b100, SLT = 3'b101;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   ctrl;
  } op_t;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic         req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] resp_result, alu_in_a, alu_in_b, alu_result;
  logic         resp_zero, alu_zero, busy, grant_id;
  logic [2:0]   alu_ctrl;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  op_t          q0[$], q1[$];
  int           grants[$], gcyc[$];
  logic [W-1:0] results[$];
  logic         zeros[$];
  logic         acc0 = 1'b0, acc1 = 1'b0;

  alu_arbiter #(.PC_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] c);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      ANDO:    return a & b;
      ORO:     return a | b;
      XORO:    return a ^ b;
      SLT:     return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  assign alu_result = alu_fn(alu_in_a, alu_in_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Clients: present the head of their queue until accepted, scramble operands otherwise.
  initial begin
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    forever begin
      @(posedge clk); #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1; req0_a = q0[0].a; req0_b = q0[0].b; req0_ctrl = q0[0].ctrl;
      end else begin
        req0_valid = 0; req0_a = W'($urandom); req0_b = W'($urandom); req0_ctrl = 3'($urandom);
      end
    end
  end

  initial begin
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    forever begin
      @(posedge clk); #1;
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid = 1; req1_a = q1[0].a; req1_b = q1[0].b; req1_ctrl = q1[0].ctrl;
      end else begin
        req1_valid = 0; req1_a = W'($urandom); req1_b = W'($urandom); req1_ctrl = 3'($urandom);
      end
    end
  end

  // Transaction-level model: one operation in flight, result visible one cycle after accept.
  logic         m_busy = 0, m_owner = 0, m_prio = 0, m_done_exec = 0, m_zero = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_result = '0;
  logic [2:0]   m_ctrl = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_prio = 0; m_done_exec = 0;
      m_a = '0; m_b = '0; m_ctrl = '0; m_result = '0; m_zero = 0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_owner = (req0_valid && req1_valid) ? m_prio : req1_valid;
        m_a     = m_owner ? req1_a    : req0_a;
        m_b     = m_owner ? req1_b    : req0_b;
        m_ctrl  = m_owner ? req1_ctrl : req0_ctrl;
        m_busy = 1; m_done_exec = 0;
      end
    end else if (!m_done_exec) begin
      m_result = alu_fn(m_a, m_b, m_ctrl);
      m_zero   = (m_result == '0);
      m_done_exec = 1;
    end else if (m_owner ? resp1_ready : resp0_ready) begin
      m_busy = 0;
      m_prio = ~m_owner;
    end
  end

  // Compare process and logging, away from the active edge.
  initial forever begin
    logic e_rdy0, e_rdy1;
    @(negedge clk);
    acc0 = req0_ready;
    acc1 = req1_ready;
    if (req0_ready) begin grants.push_back(0); gcyc.push_back(cyc); end
    if (req1_ready) begin grants.push_back(1); gcyc.push_back(cyc); end
    if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
      results.push_back(resp_result);
      zeros.push_back(resp_zero);
    end
    if (rst_n) begin
      e_rdy0 = !m_busy && req0_valid && !(req1_valid && m_prio);
      e_rdy1 = !m_busy && req1_valid && !(req0_valid && !m_prio);
      check("m_req0_ready",  32'(req0_ready),  32'(e_rdy0));
      check("m_req1_ready",  32'(req1_ready),  32'(e_rdy1));
      check("m_resp0_valid", 32'(resp0_valid), 32'(m_busy && m_done_exec && !m_owner));
      check("m_resp1_valid", 32'(resp1_valid), 32'(m_busy && m_done_exec && m_owner));
      check("m_busy",        32'(busy),        32'(m_busy));
      check("m_grant_id",    32'(grant_id),    32'(m_owner));
      check("m_resp_result", 32'(resp_result), 32'(m_result));
      check("m_resp_zero",   32'(resp_zero),   32'(m_zero));
      check("m_alu_in_a",    32'(alu_in_a),    32'(m_a));
      check("m_alu_in_b",    32'(alu_in_b),    32'(m_b));
      check("m_alu_ctrl",    32'(alu_ctrl),    32'(m_ctrl));
    end
  end

  function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    op_t o;
    o.a = a; o.b = b; o.ctrl = c;
    return o;
  endfunction

  // which: 0 = all work drained, 1 = resp0_valid high, 2 = operation sitting in EXEC.
  task automatic wait_until(input int which, input string name);
    int  n = 0;
    logic ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      case (which)
        0:       ok = (q0.size() == 0) && (q1.size() == 0) && !busy && !req0_valid && !req1_valid;
        1:       ok = resp0_valid;
        default: ok = busy && !resp0_valid && !resp1_valid;
      endcase
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_resp0_valid"}, 32'(resp0_valid), 32'd0);
    check({tag, "_resp1_valid"}, 32'(resp1_valid), 32'd0);
    check({tag, "_req0_ready"},  32'(req0_ready),  32'd0);
    check({tag, "_resp_result"}, 32'(resp_result), 32'd0);
    check({tag, "_resp_zero"},   32'(resp_zero),   32'd0);
    check({tag, "_alu_in_a"},    32'(alu_in_a),    32'd0);
    check({tag, "_alu_in_b"},    32'(alu_in_b),    32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #1 rst_n = 0;
    #1 check_reset_outputs(tag);
    #1 rst_n = 1;
  endtask

  task automatic clear_logs();
    grants.delete(); gcyc.delete(); results.delete(); zeros.delete();
  endtask

  initial begin
    rst_n = 0; resp0_ready = 1; resp1_ready = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    #1 rst_n = 1;

    // Single add from requester 0, operands scrambled right after accept.
    @(negedge clk);
    q0.push_back(mk(16'h0005, 16'h0003, ADD));
    @(negedge clk);
    check("t1_req0_ready", 32'(req0_ready), 32'd1);
    check("t1_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("t1_exec_busy",  32'(busy),        32'd1);
    check("t1_exec_rv0",   32'(resp0_valid), 32'd0);
    check("t1_alu_in_a",   32'(alu_in_a),    32'h0005);
    check("t1_alu_in_b",   32'(alu_in_b),    32'h0003);
    check("t1_alu_ctrl",   32'(alu_ctrl),    32'd0);
    @(negedge clk);
    check("t1_resp0_valid", 32'(resp0_valid), 32'd1);
    check("t1_resp1_valid", 32'(resp1_valid), 32'd0);
    check("t1_result",      32'(resp_result), 32'h0008);
    check("t1_zero",        32'(resp_zero),   32'd0);
    @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);

    // Both requesters always valid: grants alternate starting from requester 0.
    pulse_reset("rst_a");
    @(negedge clk);
    clear_logs();
    q0.push_back(mk(16'h0007, 16'h0007, SUB));
    q0.push_back(mk(16'h00F0, 16'h0F0F, ORO));
    q1.push_back(mk(16'h0002, 16'h0009, SLT));
    q1.push_back(mk(16'hFFFF, 16'h0001, ADD));
    wait_until(0, "t2_drain");
    check("t2_ngrant", 32'(grants.size()), 32'd4);
    if (grants.size() == 4 && results.size() == 4) begin
      check("t2_g0", 32'(grants[0]), 32'd0);
      check("t2_g1", 32'(grants[1]), 32'd1);
      check("t2_g2", 32'(grants[2]), 32'd0);
      check("t2_g3", 32'(grants[3]), 32'd1);
      check("t2_r0", 32'(results[0]), 32'h0000);
      check("t2_z0", 32'(zeros[0]),   32'd1);
      check("t2_r1", 32'(results[1]), 32'h0001);
      check("t2_z1", 32'(zeros[1]),   32'd0);
      check("t2_r2", 32'(results[2]), 32'h0FFF);
      check("t2_r3", 32'(results[3]), 32'h0000);
      check("t2_z3", 32'(zeros[3]),   32'd1);
    end

    // Lone requester 1 served back-to-back at three-cycle spacing.
    @(negedge clk);
    clear_logs();
    q1.push_back(mk(16'h0003, 16'h0004, ADD));
    q1.push_back(mk(16'h000A, 16'h0003, SUB));
    q1.push_back(mk(16'h8000, 16'h0001, SLT));
    wait_until(0, "t3_drain");
    check("t3_ngrant", 32'(grants.size()), 32'd3);
    if (grants.size() == 3 && results.size() == 3) begin
      check("t3_g0", 32'(grants[0]), 32'd1);
      check("t3_g1", 32'(grants[1]), 32'd1);
      check("t3_g2", 32'(grants[2]), 32'd1);
      check("t3_sp1", 32'(gcyc[1] - gcyc[0]), 32'd3);
      check("t3_sp2", 32'(gcyc[2] - gcyc[1]), 32'd3);
      check("t3_r0", 32'(results[0]), 32'h0007);
      check("t3_r1", 32'(results[1]), 32'h0007);
      check("t3_r2", 32'(results[2]), 32'h0001);
    end

    // Backpressure on requester 0 while requester 1 waits.
    resp0_ready = 0;
    q0.push_back(mk(16'h1234, 16'h0001, ADD));
    wait_until(1, "t4_resp0");
    q1.push_back(mk(16'h00FF, 16'hFF00, ORO));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_rv0",    32'(resp0_valid), 32'd1);
      check("t4_result", 32'(resp_result), 32'h1235);
      check("t4_busy",   32'(busy),        32'd1);
      check("t4_req1_r", 32'(req1_ready),  32'd0);
    end
    resp0_ready = 1;
    @(negedge clk);
    check("t4_req1_granted", 32'(req1_ready), 32'd1);
    check("t4_req0_r",       32'(req0_ready), 32'd0);
    wait_until(0, "t4_drain");

    // Reset in EXEC and in RESP, then a fresh arbitration with prio back at 0.
    @(negedge clk);
    q0.push_back(mk(16'h0101, 16'h0202, XORO));
    wait_until(2, "t6_exec");
    pulse_reset("rst_exec");
    @(negedge clk);
    resp0_ready = 0;
    q0.push_back(mk(16'h4000, 16'h1000, SUB));
    wait_until(1, "t6_resp");
    check("t6_pre_result", 32'(resp_result), 32'h3000);
    pulse_reset("rst_resp");
    resp0_ready = 1;
    @(negedge clk);
    clear_logs();
    q1.push_back(mk(16'h0001, 16'h0001, ADD));
    q0.push_back(mk(16'h0005, 16'h0003, ADD));
    wait_until(0, "t6_drain");
    if (grants.size() == 2 && results.size() == 2) begin
      check("t6_g0", 32'(grants[0]), 32'd0);
      check("t6_g1", 32'(grants[1]), 32'd1);
      check("t6_r0", 32'(results[0]), 32'h0008);
      check("t6_r1", 32'(results[1]), 32'h0002);
    end else begin
      check("t6_count", 32'(grants.size()), 32'd2);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
